// File: rtl/regfile_alu_ctrl_if.sv
// Instruction handshake and register-file port bundle for the sequencer/ALU stage.
// The master side is the instruction source plus the register file; the slave side is the controller.
interface regfile_alu_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs;
    logic [ADDR_W-1:0] instr_rt;
    logic [ADDR_W-1:0] ReadRegEven;
    logic [ADDR_W-1:0] ReadRegOdd;
    logic [DATA_W-1:0] ReadDataEven;
    logic [DATA_W-1:0] ReadDataOdd;
    logic              WriteEn;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
        output ReadDataEven, ReadDataOdd,
        input  instr_ready, ReadRegEven, ReadRegOdd,
        input  WriteEn, WriteReg, WriteData
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
        input  ReadDataEven, ReadDataOdd,
        output instr_ready, ReadRegEven, ReadRegOdd,
        output WriteEn, WriteReg, WriteData
    );
endinterface

// File: rtl/regfile_alu_ctrl.sv
// Serialized sequencer/ALU stage around a 2R/1W register file: accept, read operands,
// execute, write back; one instruction in flight at a time.
module regfile_alu_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    regfile_alu_ctrl_if.slave bus,
    output logic              busy,
    output logic              flag_zero,
    output logic              flag_carry
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    state_t            stateReg, stateNext;
    logic [2:0]        opReg;
    logic [ADDR_W-1:0] rdReg, rsReg, rtReg;
    logic [DATA_W-1:0] opAReg, opBReg;
    logic [DATA_W-1:0] resultReg;
    logic [ADDR_W-1:0] writeRegReg;
    logic              zeroReg, carryReg;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateReg <= IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (bus.instr_valid) stateNext = READ;
            READ:    stateNext = EXEC;
            EXEC:    stateNext = WB;
            WB:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Carry and borrow both fall out of a DATA_W+1 wide add/subtract.
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        case (opReg)
            OP_ADD: {aluCarry, aluResult} = {1'b0, opAReg} + {1'b0, opBReg};
            OP_SUB: {aluCarry, aluResult} = {1'b0, opAReg} - {1'b0, opBReg};
            OP_AND: aluResult = opAReg & opBReg;
            OP_OR:  aluResult = opAReg | opBReg;
            OP_XOR: aluResult = opAReg ^ opBReg;
            OP_SHL: begin
                aluResult = {opAReg[DATA_W-2:0], 1'b0};
                aluCarry  = opAReg[DATA_W-1];
            end
            OP_SHR: begin
                aluResult = {1'b0, opAReg[DATA_W-1:1]};
                aluCarry  = opAReg[0];
            end
            OP_MOV: aluResult = opAReg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg       <= '0;
            rdReg       <= '0;
            rsReg       <= '0;
            rtReg       <= '0;
            opAReg      <= '0;
            opBReg      <= '0;
            resultReg   <= '0;
            writeRegReg <= '0;
            zeroReg     <= 1'b0;
            carryReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: if (bus.instr_valid) begin
                    opReg <= bus.instr_op;
                    rdReg <= bus.instr_rd;
                    rsReg <= bus.instr_rs;
                    rtReg <= bus.instr_rt;
                end
                READ: begin
                    opAReg <= bus.ReadDataEven;
                    opBReg <= bus.ReadDataOdd;
                end
                // Write address/data are captured here so they hold outside WB.
                EXEC: begin
                    resultReg   <= aluResult;
                    writeRegReg <= rdReg;
                    zeroReg     <= (aluResult == '0);
                    carryReg    <= aluCarry;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (stateReg == IDLE);
    assign bus.ReadRegEven = rsReg;
    assign bus.ReadRegOdd  = rtReg;
    assign bus.WriteEn     = (stateReg == WB);
    assign bus.WriteReg    = writeRegReg;
    assign bus.WriteData   = resultReg;
    assign busy            = (stateReg != IDLE);
    assign flag_zero       = zeroReg;
    assign flag_carry      = carryReg;
endmodule
